// File: rtl/data_mem_stage.sv
// Data-memory stage for the MEM pipeline stage: a word array with byte write enables,
// fixed access latency, a single outstanding request, error flagging and a drain-then-halt mode.
module data_mem_stage #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 1024,
  parameter int LAT   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_wr,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [DW/8-1:0] req_be,
  input  logic            halt,
  output logic            req_ready,
  output logic            stall,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            halted
);

  localparam int NB  = DW / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HALTED} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]   be_q, be_d;
  logic            halt_seen_q, halt_seen_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_sel_q, rsp_sel_d;

  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   mem_rdata_q;

  logic            do_op;
  logic            op_wr;
  logic [AW-1:0]   op_addr;
  logic [DW-1:0]   op_wdata;
  logic [NB-1:0]   op_be;
  logic [AW-1:0]   word_idx;
  logic            op_err;
  logic            mem_we;
  logic [IW-1:0]   mem_idx;

  // With LAT==1 the op executes on the accept edge, so operands come straight from the request.
  always_comb begin
    op_wr    = (state_q == S_IDLE) ? req_wr    : wr_q;
    op_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    op_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    op_be    = (state_q == S_IDLE) ? req_be    : be_q;
    word_idx = op_addr >> OFF;
    op_err   = ((op_addr & AW'(NB - 1)) != '0) || (word_idx >= AW'(DEPTH));
    mem_idx  = word_idx[IW-1:0];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    halt_seen_d = halt_seen_q;
    rsp_err_d   = rsp_err_q;
    rsp_sel_d   = rsp_sel_q;
    do_op       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (halt) begin
          state_d = S_HALTED;
        end else if (req_valid) begin
          wr_d        = req_wr;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          be_d        = req_be;
          cnt_d       = CW'(LAT - 1);
          halt_seen_d = 1'b0;
          if (LAT == 1) begin
            state_d = S_RESP;
            do_op   = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (halt) halt_seen_d = 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_RESP;
          do_op   = 1'b1;
        end
      end
      S_RESP: begin
        state_d = (halt_seen_q || halt) ? S_HALTED : S_IDLE;
      end
      default: begin
        state_d = S_HALTED;
      end
    endcase
    if (do_op) begin
      rsp_err_d = op_err;
      rsp_sel_d = !op_wr && !op_err;
    end
    mem_we = do_op && op_wr && !op_err && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      halt_seen_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_sel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      halt_seen_q <= halt_seen_d;
      rsp_err_q   <= rsp_err_d;
      rsp_sel_q   <= rsp_sel_d;
    end
  end

  // Array is left unreset so it maps onto block RAM; the read port is registered.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (op_be[b]) mem[mem_idx][8*b +: 8] <= op_wdata[8*b +: 8];
      end
    end
    if (do_op) mem_rdata_q <= mem[mem_idx];
  end

  assign req_ready = (state_q == S_IDLE) && !halt;
  assign stall     = ((state_q == S_IDLE) && req_valid && !halt) || (state_q == S_WAIT);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_sel_q ? mem_rdata_q : '0;
  assign rsp_err   = rsp_err_q;
  assign halted    = (state_q == S_HALTED);

endmodule
